// File: rtl/core_run_ctrl.sv
// Run controller for the RV32I single-cycle core: streams a program into
// instruction memory, holds the core in reset, runs it and records why it stopped.
module core_run_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 1000,
   parameter int RST_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [31:0]         load_data,
   input  logic                load_last,
   input  logic                run_start,
   input  logic                halt_req,
   input  logic [31:0]         core_instr,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   output logic                core_rst,
   output logic                core_enable,
   output logic                busy,
   output logic                done,
   output logic [1:0]          halt_cause,
   output logic [CNT_W-1:0]    cycle_count,
   output logic [ADDR_W:0]     load_count,
   output logic                load_full,
   output logic [2:0]          state_dbg
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RESET = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

   localparam logic [1:0] CAUSE_HOST    = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_ECALL   = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   logic [2:0]        state;
   logic [RC_W-1:0]   rst_cnt;
   logic [ADDR_W-1:0] ptr;
   logic              accept;
   logic              run_exit;
   logic [1:0]        exit_cause;

   // Load handshake: a word transfers on a rising edge where load_valid and
   // load_ready are both high; load_valid may rise at any time and must hold
   // with load_data/load_last until that edge. halt_req in the same cycle wins
   // and the offered word is dropped.
   assign accept = (state == S_LOAD) && load_valid && !halt_req;

   // The write pointer is the low part of the word count; the MSB only
   // becomes set once the whole memory has been filled.
   assign ptr = load_count[ADDR_W-1:0];

   always_comb begin
      run_exit   = 1'b0;
      exit_cause = CAUSE_HOST;
      if (halt_req) begin
         run_exit   = 1'b1;
         exit_cause = CAUSE_HOST;
      end else if (core_instr == INSTR_EBREAK) begin
         run_exit   = 1'b1;
         exit_cause = CAUSE_EBREAK;
      end else if (core_instr == INSTR_ECALL) begin
         run_exit   = 1'b1;
         exit_cause = CAUSE_ECALL;
      end else if (TO_EN && (cycle_count == TO_LAST)) begin
         run_exit   = 1'b1;
         exit_cause = CAUSE_TIMEOUT;
      end
   end

   always_comb begin
      core_rst    = (state == S_IDLE) || (state == S_LOAD) || (state == S_RESET);
      core_enable = (state == S_RUN);
      load_ready  = (state == S_LOAD);
      busy        = (state == S_LOAD) || (state == S_RESET) || (state == S_RUN);
      done        = (state == S_HALT);
      state_dbg   = state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         halt_cause  <= CAUSE_HOST;
         cycle_count <= '0;
         load_count  <= '0;
         load_full   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (load_start) begin
                  state      <= S_LOAD;
                  load_count <= '0;
                  load_full  <= 1'b0;
               end else if (run_start) begin
                  state       <= S_RESET;
                  rst_cnt     <= '0;
                  cycle_count <= '0;
                  halt_cause  <= CAUSE_HOST;
               end
            end
            S_LOAD: begin
               if (halt_req) begin
                  state <= S_IDLE;
               end else if (accept) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr;
                  imem_wdata <= load_data;
                  load_count <= load_count + 1'b1;
                  if (ptr == PTR_LAST) begin
                     load_full <= 1'b1;
                     state     <= S_IDLE;
                  end else if (load_last) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_RESET: begin
               if (rst_cnt == RC_LAST) begin
                  state <= S_RUN;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            S_RUN: begin
               // The exiting cycle is still counted: the core executed it.
               if (cycle_count != CNT_MAX) begin
                  cycle_count <= cycle_count + 1'b1;
               end
               if (run_exit) begin
                  state      <= S_HALT;
                  halt_cause <= exit_cause;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run controller for the RV32I single-cycle core. It loads a program into instruction memory from a host stream and holds the core in reset for a set number of cycles. It then enables the core and counts execution cycles. Execution stops on EBREAK, ECALL, host halt request or cycle timeout. It sits between the testbench or host and the microprocessor's clk/rst/enable/instruction-memory interface.

Parameters:
ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W words)
CNT_W, 32, cycle counter width
TIMEOUT, 1000, maximum RUN cycles before forced halt; 0 disables timeout
RST_CYCLES, 2, cycles core_rst is held in RESET state before RUN (min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset of this block
load_start  in  1  pulse: begin program load
load_valid  in  1  host word valid
load_ready  out  1  controller accepts a word (handshake = valid & ready)
load_data  in  32  program word
load_last  in  1  marks final word of the program
run_start  in  1  pulse: reset core and run
halt_req  in  1  host halt/abort request
core_instr  in  32  instruction currently executing in the core
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  instruction-memory word address
imem_wdata  out  32  instruction-memory write data
core_rst  out  1  core reset, active-high
core_enable  out  1  core execution enable
busy  out  1  state is LOAD, RESET or RUN
done  out  1  state is HALT
halt_cause  out  2  0 host halt, 1 EBREAK, 2 ECALL, 3 timeout
cycle_count  out  CNT_W  RUN cycles executed in last/current run
load_count  out  ADDR_W+1  words written in last load
load_full  out  1  last load stopped at memory end

Behaviour:
- States: IDLE, LOAD, RESET, RUN, HALT.
- Reset (async, rst=1): state IDLE; core_rst=1; core_enable=0; load_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; busy=0; halt_cause=0; cycle_count=0; load_count=0; load_full=0.
- Reset asserted mid-operation aborts immediately to these values, with no further imem writes.
- Decoded from the state register:
  - core_rst=1 in IDLE, LOAD and RESET; 0 in RUN and HALT. HALT keeps core state inspectable.
  - core_enable=1 only in RUN.
  - load_ready=1 only in LOAD.
- IDLE and HALT:
  - load_start moves to LOAD and clears load_count, load_full and the write pointer.
  - If load_start is absent, run_start moves to RESET. load_start has priority when both are asserted.
  - Any transition out of HALT clears done.
- LOAD:
  - On each handshake, the next cycle has imem_we=1, imem_addr=pointer and imem_wdata=load_data; the pointer and load_count then increment.
  - imem_we is a single-cycle registered pulse per word.
  - A handshake with load_last=1 returns to IDLE next cycle.
  - A handshake at pointer 2^ADDR_W-1 writes that word, sets load_full=1 and returns to IDLE. Further words are not accepted.
  - halt_req returns to IDLE without writing. Words already written stay valid.
  - run_start is ignored in LOAD.
- RESET: entry clears cycle_count and halt_cause. The state holds for exactly RST_CYCLES cycles, then moves to RUN.
- RUN:
  - Each cycle, cycle_count increments, saturating at all-ones.
  - Exit checks are evaluated on the current-cycle inputs, in this priority order:
    1. halt_req gives cause 0.
    2. core_instr==0x00100073 (EBREAK) gives cause 1.
    3. core_instr==0x00000073 (ECALL) gives cause 2.
    4. TIMEOUT!=0 and pre-increment cycle_count==TIMEOUT-1 gives cause 3.
  - On any exit: next state HALT, halt_cause registered, done=1. core_enable drops on the following cycle, so the triggering instruction's cycle is counted.
- busy is registered consistently with state; done and busy are never both 1.

Test Plan:
1. Reset mid-RUN: assert rst during the 3rd RUN cycle -> same cycle core_enable=0, core_rst=1, busy=0, done=0, cycle_count=0.
2. Load 3 words: 0x00500093, 0x00108113, 0x00100073 with last on word 3 -> imem_we pulses with addr 0,1,2 and matching data; load_count=3; load_full=0; state IDLE; load_ready=0.
3. Run with RST_CYCLES=2; core_instr=0x00000013 for 5 RUN cycles, then 0x00100073 -> core_rst high exactly 2 cycles; core_enable high 6 cycles; halt_cause=1; cycle_count=6; done=1.
4. Timeout with TIMEOUT=16, core_instr held at 0x00000013 -> exactly 16 RUN cycles; halt_cause=3; cycle_count=16. Repeat with TIMEOUT=0 for 100 cycles -> still RUN.
5. Simultaneous halt_req and core_instr=0x00000073 in the same RUN cycle -> halt_cause=0. Then run_start from HALT -> cycle_count cleared and RESET re-entered.
6. Overflow with ADDR_W=2: offer 5 words, no last -> 4 writes (addr 0-3), load_full=1, load_count=4, word 5 never accepted. Back-to-back valid yields one write per cycle.
